pet_stats_engine: RTL and testbench
===================================

PET_STATS_ENGINE -- requirements
Module: pet_stats_engine

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 24'd10_000_000, meaning the clk cycles per decay tick (legal range 2..2^24-1).
REQ-002 SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-004 SHALL have port inputs, input, 8, meaning care buttons, asynchronous to clk: bit0 feed, bit1 play, bit2 medicine, bit3 clean, bit4 sleep, bit5 socialize, bit6 reserved (ignored), bit7 pause (level).
REQ-005 SHALL have ports hunger, happiness, health, hygiene, energy, social, each output, 4, meaning the pet stats consumed by the status evaluator, with 15 = best and 0 = worst.
REQ-006 SHALL have port tick, output, 1, meaning a one-cycle pulse at each decay tick.
REQ-007 SHALL have port alive, output, 1, meaning high unless in DEAD.
REQ-008 SHALL have port mode, output, 2, meaning the FSM state: 00 ALIVE, 01 PAUSED, 10 DEAD.

Function
REQ-009 SHALL synchronize each inputs bit through two flops, and form a rising-edge pulse for bits 0-5 by comparing the second sync flop with a third history flop.
REQ-010 SHALL apply an action with a net latency of 3 clk edges: a button rising before edge k SHALL change the stat outputs after edge k+2. A held button SHALL act once only.
REQ-011 SHALL use a 24-bit tick counter that counts 0..MAX_COUNT-1 and wraps to 0, with tick=1 in the cycle where the count equals MAX_COUNT-1.
REQ-012 SHALL hold the tick counter in PAUSED and DEAD, with tick=0 in those states.
REQ-013 SHALL use a 2-bit phase counter that increments (wrapping 3->0) in each tick cycle, and use it to select which stats decay.
REQ-014 SHALL apply decay in each tick cycle, with "phase" meaning the value before the increment:
- hunger -1 on every tick.
- happiness and hygiene -1 when phase bit0=1.
- energy and social -1 when phase=3.
- health -1 when hunger==0 or hygiene==0 (values before the update).
REQ-015 SHALL apply action increments:
- feed: hunger +4.
- play: happiness +3 and energy -2.
- medicine: health +4.
- clean: hygiene +5.
- sleep: energy +6.
- socialize: social +3 and happiness +1.
REQ-016 SHALL, for each stat every cycle, compute next = current + sum(increments) - sum(decrements) in signed 7-bit arithmetic, then clamp to 0..15. Simultaneous actions and a tick in the same cycle SHALL all combine in this single sum.
REQ-017 FSM, from ALIVE:
- -> PAUSED when synchronized bit7=1.
- -> DEAD when next health==0.
- DEAD takes priority over PAUSED.
REQ-018 FSM, from PAUSED: -> ALIVE when synchronized bit7=0. In PAUSED no decay SHALL occur, but actions SHALL still apply.
REQ-019 FSM, DEAD: terminal until reset. All stats SHALL be frozen, actions ignored, and alive=0.
REQ-020 The edge history flops SHALL keep updating in every state, so that releasing pause or reset does not replay held buttons.

Reset
REQ-021 Asserting reset SHALL immediately (asynchronously) set:
- hunger=happiness=hygiene=energy=social=12, health=15.
- tick counter=0, phase=0.
- all sync and history flops=0.
- mode=ALIVE, tick=0, alive=1.
REQ-022 Reset asserted mid-operation (including in DEAD or PAUSED) SHALL abort all pending updates. The first action or tick SHALL be evaluable only after reset deasserts.

Verification
REQ-023 Tick and decay: MAX_COUNT=4, no inputs, after reset -> tick every 4th cycle. After 4 ticks: hunger=8, happiness=10, hygiene=10, energy=11, social=11, health=15.
REQ-024 Action latency, saturation and single-fire: pulse feed for 1 cycle at hunger=12 -> hunger=15 exactly 3 edges later (clamped). Holding feed for 20 cycles -> only one increment.
REQ-025 Simultaneous events: play pressed so that it lands in a phase-3 tick cycle with energy=1 -> energy=0 (1-2-1 clamped), happiness +3-1.
REQ-026 Pause: bit7=1 for 50 cycles with MAX_COUNT=4 -> mode=01, tick=0, no decay, clean still raises hygiene. Release -> ALIVE, and the tick counter resumes from its held value.
REQ-027 Death and reset: force hunger=0 via ticks until health reaches 0 -> mode=10, alive=0, stats frozen, feed ignored. Assert reset mid-cycle -> outputs return to 12/15 values at once, with mode=00.

Source files
------------

// File: rtl/pet_stats_engine.sv
// pet_stats_engine
//   Virtual-pet stat engine. Six 4-bit stats (15 = best, 0 = worst) decay on a
//   periodic tick and are raised by debounced-free care buttons. A three-state
//   FSM (ALIVE / PAUSED / DEAD) gates decay and actions.
//
// Ports
//   clk        : system clock, all state changes on its rising edge
//   reset      : asynchronous active-high reset
//   inputs[7:0]: async buttons; 0 feed, 1 play, 2 medicine, 3 clean,
//                4 sleep, 5 socialize, 6 reserved, 7 pause (level)
//   hunger, happiness, health, hygiene, energy, social : stat outputs
//   tick       : one-cycle pulse on each decay tick
//   alive      : high unless DEAD
//   mode       : 00 ALIVE, 01 PAUSED, 10 DEAD
module pet_stats_engine #(
    parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] inputs,
    output logic [3:0] hunger,
    output logic [3:0] happiness,
    output logic [3:0] health,
    output logic [3:0] hygiene,
    output logic [3:0] energy,
    output logic [3:0] social,
    output logic       tick,
    output logic       alive,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'b00,
        ST_PAUSED = 2'b01,
        ST_DEAD   = 2'b10
    } state_t;

    localparam int HUN = 0;
    localparam int HAP = 1;
    localparam int HEA = 2;
    localparam int HYG = 3;
    localparam int ENE = 4;
    localparam int SOC = 5;

    // Clamp a signed working sum back into the 0..15 stat range.
    function automatic logic [3:0] sat4(input logic signed [6:0] v);
        if (v < 7'sd0)       return 4'd0;
        else if (v > 7'sd15) return 4'd15;
        else                 return v[3:0];
    endfunction

    logic [7:0]  sync_p0_q, sync_p0_d;
    logic [7:0]  sync_p1_q, sync_p1_d;
    logic [5:0]  hist_p2_q, hist_p2_d;
    logic [23:0] cnt_q, cnt_d;
    logic [1:0]  phase_q, phase_d;
    state_t      state_q, state_d;
    logic        alive_q, alive_d;
    logic [3:0]  stat_q [6];
    logic [3:0]  stat_d [6];

    logic [5:0]        act;
    logic              tick_w;
    logic signed [6:0] sum [6];
    logic              unused_rsvd;

    assign unused_rsvd = sync_p1_q[6];

    always_comb begin
        // Input synchronizer and edge history always run, in every state.
        sync_p0_d = inputs;
        sync_p1_d = sync_p0_q;
        hist_p2_d = sync_p1_q[5:0];

        tick_w = (state_q == ST_ALIVE) && (cnt_q == MAX_COUNT - 24'd1);
        act    = (state_q == ST_DEAD) ? 6'd0 : (sync_p1_q[5:0] & ~hist_p2_q);

        for (int i = 0; i < 6; i++) begin
            sum[i] = signed'({3'b000, stat_q[i]});
        end

        if (act[0]) sum[HUN] = sum[HUN] + 7'sd4;
        if (act[1]) begin
            sum[HAP] = sum[HAP] + 7'sd3;
            sum[ENE] = sum[ENE] - 7'sd2;
        end
        if (act[2]) sum[HEA] = sum[HEA] + 7'sd4;
        if (act[3]) sum[HYG] = sum[HYG] + 7'sd5;
        if (act[4]) sum[ENE] = sum[ENE] + 7'sd6;
        if (act[5]) begin
            sum[SOC] = sum[SOC] + 7'sd3;
            sum[HAP] = sum[HAP] + 7'sd1;
        end

        // Decay uses the phase value before this tick's increment, and the
        // health penalty looks at hunger/hygiene before this cycle's update.
        if (tick_w) begin
            sum[HUN] = sum[HUN] - 7'sd1;
            if (phase_q[0]) begin
                sum[HAP] = sum[HAP] - 7'sd1;
                sum[HYG] = sum[HYG] - 7'sd1;
            end
            if (phase_q == 2'd3) begin
                sum[ENE] = sum[ENE] - 7'sd1;
                sum[SOC] = sum[SOC] - 7'sd1;
            end
            if ((stat_q[HUN] == 4'd0) || (stat_q[HYG] == 4'd0)) begin
                sum[HEA] = sum[HEA] - 7'sd1;
            end
        end

        for (int i = 0; i < 6; i++) begin
            stat_d[i] = (state_q == ST_DEAD) ? stat_q[i] : sat4(sum[i]);
        end

        // Tick counter and phase only advance while ALIVE.
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (state_q == ST_ALIVE) begin
            cnt_d = tick_w ? 24'd0 : cnt_q + 24'd1;
        end
        if (tick_w) begin
            phase_d = phase_q + 2'd1;
        end

        state_d = state_q;
        case (state_q)
            ST_ALIVE: begin
                if (stat_d[HEA] == 4'd0)  state_d = ST_DEAD;
                else if (sync_p1_q[7])    state_d = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (!sync_p1_q[7])        state_d = ST_ALIVE;
            end
            default:                      state_d = ST_DEAD;
        endcase
        alive_d = (state_d != ST_DEAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0_q <= 8'd0;
            sync_p1_q <= 8'd0;
            hist_p2_q <= 6'd0;
            cnt_q     <= 24'd0;
            phase_q   <= 2'd0;
            state_q   <= ST_ALIVE;
            alive_q   <= 1'b1;
            for (int i = 0; i < 6; i++) begin
                stat_q[i] <= (i == HEA) ? 4'd15 : 4'd12;
            end
        end else begin
            sync_p0_q <= sync_p0_d;
            sync_p1_q <= sync_p1_d;
            hist_p2_q <= hist_p2_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            state_q   <= state_d;
            alive_q   <= alive_d;
            for (int i = 0; i < 6; i++) begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    assign hunger    = stat_q[HUN];
    assign happiness = stat_q[HAP];
    assign health    = stat_q[HEA];
    assign hygiene   = stat_q[HYG];
    assign energy    = stat_q[ENE];
    assign social    = stat_q[SOC];
    assign tick      = tick_w;
    assign alive     = alive_q;
    assign mode      = state_q;

endmodule

// File: tb/tb_pet_stats_engine.sv
// Testbench for pet_stats_engine: directed scenarios followed by random button
// traffic, every cycle compared against a behavioural model of the pet.
module tb_pet_stats_engine;

    localparam int MC = 4;

    logic       clk;
    logic       reset;
    logic [7:0] inputs;
    logic [3:0] hunger, happiness, health, hygiene, energy, social;
    logic       tick, alive;
    logic [1:0] mode;

    int n_cmp;
    int n_err;

    // Model state: stats in order hunger, happiness, health, hygiene, energy, social.
    int         st [6];
    int         cnt, ph, md;
    logic [7:0] smp0, smp1, smp2;   // button samples taken at the last three edges

    pet_stats_engine #(.MAX_COUNT(24'd4)) dut (
        .clk(clk), .reset(reset), .inputs(inputs),
        .hunger(hunger), .happiness(happiness), .health(health),
        .hygiene(hygiene), .energy(energy), .social(social),
        .tick(tick), .alive(alive), .mode(mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clamp15(input int v);
        if (v < 0)  return 0;
        if (v > 15) return 15;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) st[i] = (i == 2) ? 15 : 12;
        cnt = 0; ph = 0; md = 0;
        smp0 = 8'd0; smp1 = 8'd0; smp2 = 8'd0;
    endtask

    // One clock edge of the pet: a button acts when its synchronized copy
    // (sampled two edges ago) is high and was low one edge earlier.
    task automatic model_edge(input logic [7:0] inp);
        logic [7:0] p;
        bit         tk;
        int         nx [6];
        p  = smp1 & ~smp2;
        tk = (md == 0) && (cnt == MC - 1);
        if (md != 2) begin
            for (int i = 0; i < 6; i++) nx[i] = st[i];
            if (p[0]) nx[0] += 4;
            if (p[1]) begin nx[1] += 3; nx[4] -= 2; end
            if (p[2]) nx[2] += 4;
            if (p[3]) nx[3] += 5;
            if (p[4]) nx[4] += 6;
            if (p[5]) begin nx[5] += 3; nx[1] += 1; end
            if (tk) begin
                nx[0] -= 1;
                if (ph % 2 == 1) begin nx[1] -= 1; nx[3] -= 1; end
                if (ph == 3)     begin nx[4] -= 1; nx[5] -= 1; end
                if (st[0] == 0 || st[3] == 0) nx[2] -= 1;
            end
            for (int i = 0; i < 6; i++) st[i] = clamp15(nx[i]);
            if (md == 0) begin
                cnt = (cnt + 1) % MC;
                if (tk) ph = (ph + 1) % 4;
                if (st[2] == 0)   md = 2;
                else if (smp1[7]) md = 1;
            end else if (!smp1[7]) begin
                md = 0;
            end
        end
        smp2 = smp1; smp1 = smp0; smp0 = inp;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("hunger",    {4'd0, hunger},    8'(st[0]));
        chk("happiness", {4'd0, happiness}, 8'(st[1]));
        chk("health",    {4'd0, health},    8'(st[2]));
        chk("hygiene",   {4'd0, hygiene},   8'(st[3]));
        chk("energy",    {4'd0, energy},    8'(st[4]));
        chk("social",    {4'd0, social},    8'(st[5]));
        chk("tick",      {7'd0, tick},      {7'd0, (md == 0 && cnt == MC - 1)});
        chk("alive",     {7'd0, alive},     {7'd0, (md != 2)});
        chk("mode",      {6'd0, mode},      8'(md));
    endtask

    task automatic cycle(input logic [7:0] inp);
        inputs = inp;
        @(posedge clk);
        model_edge(inp);
        #1;
        check_all();
    endtask

    // Assert reset away from the clock edge, check the immediate effect,
    // then release on a falling edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] hyg_before;
        bit         pause_on;
        int         guard;
        n_cmp = 0; n_err = 0;
        inputs = 8'd0;
        reset = 1'b0;
        model_reset();
        #2;
        do_reset();
        chk("rst_hunger", {4'd0, hunger}, 8'd12);
        chk("rst_health", {4'd0, health}, 8'd15);
        chk("rst_mode",   {6'd0, mode},   8'd0);
        chk("rst_alive",  {7'd0, alive},  8'd1);

        // Four ticks with idle buttons.
        for (int i = 0; i < 16; i++) cycle(8'h00);
        chk("decay_hunger",    {4'd0, hunger},    8'd8);
        chk("decay_happiness", {4'd0, happiness}, 8'd10);
        chk("decay_hygiene",   {4'd0, hygiene},   8'd10);
        chk("decay_energy",    {4'd0, energy},    8'd11);
        chk("decay_social",    {4'd0, social},    8'd11);
        chk("decay_health",    {4'd0, health},    8'd15);

        // Feed pulse from hunger=12: visible after the third edge, clamped.
        do_reset();
        cycle(8'h01);
        cycle(8'h00);
        chk("feed_lat2", {4'd0, hunger}, 8'd12);
        cycle(8'h00);
        chk("feed_lat3", {4'd0, hunger}, 8'd15);
        for (int i = 0; i < 20; i++) cycle(8'h01);
        for (int i = 0; i < 4; i++)  cycle(8'h00);

        // Pause for 50 cycles with a clean press in the middle.
        hyg_before = hygiene;
        for (int i = 0; i < 50; i++) cycle((i >= 20 && i < 23) ? 8'h88 : 8'h80);
        chk("pause_mode", {6'd0, mode}, 8'd1);
        chk("pause_tick", {7'd0, tick}, 8'd0);
        chk("pause_clean", {4'd0, hygiene}, 8'(clamp15(int'(hyg_before) + 5)));
        for (int i = 0; i < 8; i++) cycle(8'h00);
        chk("resume_mode", {6'd0, mode}, 8'd0);

        // Starve to death, then check freezing and reset recovery.
        guard = 0;
        while (mode != 2'b10 && guard < 1000) begin
            cycle(8'h00);
            guard++;
        end
        chk("death_reached", {7'd0, (mode == 2'b10)}, 8'd1);
        chk("death_alive",   {7'd0, alive},           8'd0);
        cycle(8'h01);
        for (int i = 0; i < 10; i++) cycle(8'h00);
        chk("dead_frozen_hunger", {4'd0, hunger}, 8'd0);
        @(posedge clk);
        model_edge(inputs);
        #3;
        do_reset();
        chk("revive_hunger", {4'd0, hunger}, 8'd12);
        chk("revive_health", {4'd0, health}, 8'd15);
        chk("revive_mode",   {6'd0, mode},   8'd0);

        // Random button traffic with pause spans and occasional resets.
        pause_on = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            logic [7:0] b;
            b = 8'd0;
            for (int j = 0; j < 7; j++) b[j] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) pause_on = ~pause_on;
            b[7] = pause_on;
            cycle(b);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
